shift_unit: RTL and testbench

Parametrised multi-cycle shifter, successor to the fixed 4-in/8-out shift register in the datapath. It loads a zero-extended operand and then runs a handshaked shift of 0..2^SHAMT_WIDTH-1 positions, one bit per cycle. Modes are LSL, LSR, ASR, ROL and ROR. It provides a carry flag, a zero flag and busy/done status for the controller FSM.

---
 rtl/shift_unit_if.sv | 27 ++
 rtl/shift_unit.sv | 132 +++++++++++++
 tb/tb_shift_unit.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_unit_if.sv
// Operand load, shift command and status signals between the datapath controller and shift_unit.
interface shift_unit_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned IN_WIDTH    = 4,
  parameter int unsigned SHAMT_WIDTH = 3
);
  logic                   load;
  logic [IN_WIDTH-1:0]    load_data;
  logic                   start;
  logic [2:0]             mode;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  out;
  logic                   carry;
  logic                   zero;
  logic                   busy;
  logic                   done;

  modport master (
    output load, load_data, start, mode, shamt,
    input  out, carry, zero, busy, done
  );

  modport slave (
    input  load, load_data, start, mode, shamt,
    output out, carry, zero, busy, done
  );
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle 1-bit-per-cycle shifter: load operand, then LSL/LSR/ASR/ROL/ROR by shamt with carry, zero and busy/done status.
module shift_unit #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned IN_WIDTH    = 4,
  parameter int unsigned SHAMT_WIDTH = 3
) (
  input logic          clk,
  input logic          reset,
  shift_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    MODE_NOP = 3'b000,
    MODE_LSL = 3'b001,
    MODE_LSR = 3'b010,
    MODE_ASR = 3'b011,
    MODE_ROL = 3'b100,
    MODE_ROR = 3'b101
  } mode_t;

  state_t                 state;
  mode_t                  mode_q;
  logic [SHAMT_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0]  sh;
  logic                   carry_q;
  logic                   busy_q;
  logic                   done_q;

  logic [DATA_WIDTH-1:0]  sh_next;
  logic                   carry_next;
  logic                   start_nop;

  // Encodings 000, 110 and 111 all behave as a no-op shift.
  always_comb begin
    start_nop = (bus.mode == 3'b000) || (bus.mode == 3'b110) || (bus.mode == 3'b111);
  end

  always_comb begin
    sh_next    = sh;
    carry_next = carry_q;
    case (mode_q)
      MODE_LSL: begin
        sh_next    = {sh[DATA_WIDTH-2:0], 1'b0};
        carry_next = sh[DATA_WIDTH-1];
      end
      MODE_LSR: begin
        sh_next    = {1'b0, sh[DATA_WIDTH-1:1]};
        carry_next = sh[0];
      end
      MODE_ASR: begin
        sh_next    = {sh[DATA_WIDTH-1], sh[DATA_WIDTH-1:1]};
        carry_next = sh[0];
      end
      MODE_ROL: begin
        sh_next    = {sh[DATA_WIDTH-2:0], sh[DATA_WIDTH-1]};
        carry_next = sh[DATA_WIDTH-1];
      end
      MODE_ROR: begin
        sh_next    = {sh[0], sh[DATA_WIDTH-1:1]};
        carry_next = sh[0];
      end
      default: begin
        sh_next    = sh;
        carry_next = carry_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mode_q  <= MODE_NOP;
      count   <= '0;
      sh      <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.load) begin
            sh <= DATA_WIDTH'(bus.load_data);
          end else if (bus.start) begin
            mode_q <= mode_t'(bus.mode);
            busy_q <= 1'b1;
            if (bus.shamt == '0 || start_nop) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= SHIFT;
              count <= bus.shamt;
            end
          end
        end
        SHIFT: begin
          sh      <= sh_next;
          carry_q <= carry_next;
          count   <= count - 1'b1;
          // busy/done are registered, so they are set alongside the state move.
          if (count == SHAMT_WIDTH'(1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out   = sh;
  assign bus.carry = carry_q;
  assign bus.zero  = (sh == '0);
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed-vector bench for shift_unit with hand-computed expectations.
module tb_shift_unit;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  shift_unit_if #(.DATA_WIDTH(8), .IN_WIDTH(4), .SHAMT_WIDTH(3)) bus ();

  shift_unit #(.DATA_WIDTH(8), .IN_WIDTH(4), .SHAMT_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] d);
    bus.load      = 1'b1;
    bus.load_data = d;
    step();
    bus.load      = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] m, input logic [2:0] n);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.shamt = n;
    step();
    bus.start = 1'b0;
  endtask

  // Runs from just after the start edge until busy drops (bounded), counting busy and done samples.
  task automatic run_to_idle(output int busy_cyc, output int done_cyc);
    int n;
    busy_cyc = 0;
    done_cyc = 0;
    n = 0;
    if (bus.busy === 1'b1) busy_cyc++;
    if (bus.done === 1'b1) done_cyc++;
    while (bus.busy === 1'b1 && n < 40) begin
      step();
      n++;
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) done_cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vectors++;
    if (bus.out !== 8'h00 || bus.carry !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got out=%h carry=%b busy=%b done=%b, expected out=00 carry=0 busy=0 done=0",
               bus.out, bus.carry, bus.busy, bus.done);
    end
    vectors++;
    if (bus.zero !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_zero: got %b expected 1", bus.zero);
    end
    reset = 1'b0;
    do_load(4'hB);
    vectors++;
    if (bus.out !== 8'h0B || bus.carry !== 1'b0 || bus.zero !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL load_0B: got out=%h carry=%b zero=%b busy=%b, expected out=0b carry=0 zero=0 busy=0",
               bus.out, bus.carry, bus.zero, bus.busy);
    end
  endtask

  task automatic test_lsl();
    logic [7:0] exp_seq [5];
    int busy_cyc;
    int done_cyc;
    exp_seq = '{8'h16, 8'h2C, 8'h58, 8'hB0, 8'h60};
    do_start(3'b001, 3'd5);
    // Changing mode/shamt after the start edge must not affect the operation.
    bus.mode  = 3'b011;
    bus.shamt = 3'd7;
    busy_cyc = (bus.busy === 1'b1) ? 1 : 0;
    done_cyc = (bus.done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) done_cyc++;
      vectors++;
      if (bus.out !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL lsl_step%0d: got %h expected %h", i, bus.out, exp_seq[i]);
      end
    end
    vectors++;
    if (bus.carry !== 1'b1) begin
      miscompares++;
      $display("FAIL lsl_carry: got %b expected 1", bus.carry);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) done_cyc++;
    end
    vectors++;
    if (busy_cyc != 6) begin
      miscompares++;
      $display("FAIL lsl_busy_cycles: got %0d expected 6", busy_cyc);
    end
    vectors++;
    if (done_cyc != 1) begin
      miscompares++;
      $display("FAIL lsl_done_pulses: got %0d expected 1", done_cyc);
    end
  endtask

  task automatic test_asr_lsr();
    int busy_cyc;
    int done_cyc;
    do_load(4'hB);
    do_start(3'b001, 3'd4);
    run_to_idle(busy_cyc, done_cyc);
    vectors++;
    if (bus.out !== 8'hB0) begin
      miscompares++;
      $display("FAIL setup_B0: got %h expected b0", bus.out);
    end
    do_start(3'b011, 3'd2);
    step();
    vectors++;
    if (bus.out !== 8'hD8) begin
      miscompares++;
      $display("FAIL asr_step0: got %h expected d8", bus.out);
    end
    step();
    vectors++;
    if (bus.out !== 8'hEC || bus.carry !== 1'b0) begin
      miscompares++;
      $display("FAIL asr_final: got out=%h carry=%b expected out=ec carry=0", bus.out, bus.carry);
    end
    run_to_idle(busy_cyc, done_cyc);
    do_load(4'hB);
    do_start(3'b010, 3'd1);
    run_to_idle(busy_cyc, done_cyc);
    vectors++;
    if (bus.out !== 8'h05 || bus.carry !== 1'b1) begin
      miscompares++;
      $display("FAIL lsr_final: got out=%h carry=%b expected out=05 carry=1", bus.out, bus.carry);
    end
    vectors++;
    if (busy_cyc != 2 || done_cyc != 1) begin
      miscompares++;
      $display("FAIL lsr_timing: got busy=%0d done=%0d expected busy=2 done=1", busy_cyc, done_cyc);
    end
  endtask

  task automatic test_rotate();
    int busy_cyc;
    int done_cyc;
    do_load(4'hB);
    do_start(3'b101, 3'd1);
    run_to_idle(busy_cyc, done_cyc);
    vectors++;
    if (bus.out !== 8'h85 || bus.carry !== 1'b1) begin
      miscompares++;
      $display("FAIL ror_final: got out=%h carry=%b expected out=85 carry=1", bus.out, bus.carry);
    end
    do_start(3'b100, 3'd7);
    run_to_idle(busy_cyc, done_cyc);
    vectors++;
    if (bus.out !== 8'hC2 || bus.carry !== 1'b0) begin
      miscompares++;
      $display("FAIL rol7_final: got out=%h carry=%b expected out=c2 carry=0", bus.out, bus.carry);
    end
    vectors++;
    if (busy_cyc != 8 || done_cyc != 1) begin
      miscompares++;
      $display("FAIL rol7_timing: got busy=%0d done=%0d expected busy=8 done=1", busy_cyc, done_cyc);
    end
  endtask

  task automatic test_edge_cases();
    int busy_cyc;
    int done_cyc;
    do_load(4'h9);
    do_start(3'b001, 3'd0);
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL shamt0_done: got done=%b busy=%b expected done=1 busy=1", bus.done, bus.busy);
    end
    run_to_idle(busy_cyc, done_cyc);
    vectors++;
    if (bus.out !== 8'h09 || bus.carry !== 1'b0 || busy_cyc != 1 || done_cyc != 1) begin
      miscompares++;
      $display("FAIL shamt0_result: got out=%h carry=%b busy=%0d done=%0d expected out=09 carry=0 busy=1 done=1",
               bus.out, bus.carry, busy_cyc, done_cyc);
    end
    do_start(3'b110, 3'd3);
    run_to_idle(busy_cyc, done_cyc);
    vectors++;
    if (bus.out !== 8'h09 || busy_cyc != 1 || done_cyc != 1) begin
      miscompares++;
      $display("FAIL nop_mode: got out=%h busy=%0d done=%0d expected out=09 busy=1 done=1",
               bus.out, busy_cyc, done_cyc);
    end
    // Load and start while shifting must both be ignored.
    do_load(4'hB);
    do_start(3'b001, 3'd3);
    bus.load      = 1'b1;
    bus.load_data = 4'h5;
    bus.start     = 1'b1;
    step();
    step();
    bus.load  = 1'b0;
    bus.start = 1'b0;
    run_to_idle(busy_cyc, done_cyc);
    vectors++;
    if (bus.out !== 8'h58 || bus.carry !== 1'b0) begin
      miscompares++;
      $display("FAIL load_during_shift: got out=%h carry=%b expected out=58 carry=0", bus.out, bus.carry);
    end
    step();
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_during_shift: got busy=%b expected 0", bus.busy);
    end
    bus.load      = 1'b1;
    bus.load_data = 4'h3;
    bus.start     = 1'b1;
    bus.mode      = 3'b001;
    bus.shamt     = 3'd2;
    step();
    bus.load  = 1'b0;
    bus.start = 1'b0;
    vectors++;
    if (bus.out !== 8'h03 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL load_wins: got out=%h busy=%b expected out=03 busy=0", bus.out, bus.busy);
    end
    step();
    vectors++;
    if (bus.out !== 8'h03 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL load_wins_after: got out=%h busy=%b expected out=03 busy=0", bus.out, bus.busy);
    end
  endtask

  task automatic test_reset_abort();
    int done_seen;
    do_load(4'hB);
    do_start(3'b001, 3'd5);
    step();
    vectors++;
    if (bus.out !== 8'h16) begin
      miscompares++;
      $display("FAIL abort_pre: got %h expected 16", bus.out);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (bus.out !== 8'h00 || bus.carry !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.zero !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_state: got out=%h carry=%b busy=%b done=%b zero=%b expected 00/0/0/0/1",
               bus.out, bus.carry, bus.busy, bus.done, bus.zero);
    end
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d busy/done samples expected 0", done_seen);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.load      = 1'b0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    bus.mode      = '0;
    bus.shamt     = '0;
    test_reset();
    test_lsl();
    test_asr_lsr();
    test_rotate();
    test_edge_cases();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
